// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin merge path and its demux_1to4 partner.
// sel_t is the channel tag carried with every beat on the merged stream.
package mux_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    // Next channel index in round-robin order; wraps 3 -> 0 naturally.
    function automatic sel_t sel_inc(input sel_t s);
        return s + sel_t'(1);
    endfunction

endpackage

// File: rtl/mux_rr_4to1_arb.sv
// Combinational 4-way round-robin arbiter: the channel at ptr has top priority,
// then ptr+1, ptr+2, ptr+3 (mod 4). Grant is suppressed when en is low.
module rr_arbiter_4
    import mux_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  sel_t           ptr,
    input  logic           en,
    output logic [NCH-1:0] gnt_oh,
    output sel_t           gnt,
    output logic           any
);

    logic found;
    sel_t idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = ptr + sel_t'(k);
            if (!found && req[idx]) begin
                gnt   = idx;
                found = 1'b1;
            end
        end
    end

    assign any = |req;

    always_comb begin
        gnt_oh = '0;
        if (en && found) begin
            gnt_oh[gnt] = 1'b1;
        end
    end

endmodule

// File: rtl/mux_rr_4to1.sv
// 4-to-1 round-robin merge with a registered output stage and valid/ready handshake.
// The beat is tagged with its source channel on sel so demux_1to4 can route it back.
//
// state    | meaning
// ST_EMPTY | output register holds no beat (dout_valid = 0)
// ST_FULL  | output register holds a beat waiting for dout_ready
module mux_rr_4to1
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       din_valid,
    input  logic [NCH*WIDTH-1:0] din,
    output logic [NCH-1:0]       din_ready,
    output logic                 dout_valid,
    output logic [WIDTH-1:0]     dout,
    output sel_t                 sel,
    input  logic                 dout_ready
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    sel_t             sel_q, sel_d;
    sel_t             ptr_q, ptr_d;

    logic             load;
    logic [NCH-1:0]   gnt_oh;
    sel_t             gnt;
    logic             any_req;
    logic [WIDTH-1:0] din_ch [NCH];

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            din_ch[i] = din[i*WIDTH +: WIDTH];
        end
    end

    // The output stage can take a beat when it is empty or being drained this cycle.
    assign load = (state_q == ST_EMPTY) || dout_ready;

    // Gating with rst keeps producers from seeing an accept that the reset will discard.
    rr_arbiter_4 u_arb (
        .req    (din_valid),
        .ptr    (ptr_q),
        .en     (load && !rst),
        .gnt_oh (gnt_oh),
        .gnt    (gnt),
        .any    (any_req)
    );

    assign din_ready = gnt_oh;

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (load) begin
            if (any_req) begin
                state_d = ST_FULL;
                dout_d  = din_ch[gnt];
                sel_d   = gnt;
                ptr_d   = sel_inc(gnt);
            end else begin
                state_d = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            dout_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign dout_valid = (state_q == ST_FULL);
    assign dout       = dout_q;
    assign sel        = sel_q;

endmodule

// File: tb/tb_mux_rr_4to1.sv
// Directed bench for mux_rr_4to1: reset, fairness, backpressure, pointer wrap,
// sparse input and a loopback through a small demux_1to4 model.
module tb_mux_rr_4to1;
    import mux_pkg::*;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     din_valid;
    logic [4*W-1:0] din;
    logic [3:0]     din_ready;
    logic           dout_valid;
    logic [W-1:0]   dout;
    sel_t           sel;
    logic           dout_ready;

    int n_tests = 0;
    int n_fail  = 0;

    mux_rr_4to1 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .din_ready  (din_ready),
        .dout_valid (dout_valid),
        .dout       (dout),
        .sel        (sel),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
        chk({tag, ".valid"}, 32'(dout_valid), 32'(v));
        chk({tag, ".dout"},  32'(dout),       32'(d));
        chk({tag, ".sel"},   32'(sel),        32'(s));
    endtask

    // Behavioral stand-in for demux_1to4: routes the beat to lane sel.
    function automatic logic [4*W+3:0] demux_model(input logic v, input sel_t s, input logic [W-1:0] d);
        logic [4*W+3:0] r;
        r = '0;
        if (v) begin
            r[4*W + s] = 1'b1;
            r[s*W +: W] = d;
        end
        return r;
    endfunction

    logic [7:0]     fair_d [5] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA0};
    logic [1:0]     fair_s [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0]     fair_r [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [7:0]     lb_d   [2] = '{8'h55, 8'hAA};
    logic [4*W+3:0] lb;

    initial begin
        rst        = 1'b1;
        din_valid  = 4'b1111;
        dout_ready = 1'b1;
        din        = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

        #12;
        chk_out("rst_init", 1'b0, 8'h00, 2'd0);
        chk("rst_init.ready", 32'(din_ready), 32'h0);

        // First grant after reset release goes to channel 0.
        rst = 1'b0;
        #1;
        chk("fair.ready0", 32'(din_ready), 32'b0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("fair%0d", i), 1'b1, fair_d[i], fair_s[i]);
            chk($sformatf("fair%0d.ready", i), 32'(din_ready), 32'(fair_r[i]));
        end

        // Asynchronous reset while a beat is held.
        #1 rst = 1'b1;
        #1;
        chk_out("rst_mid", 1'b0, 8'h00, 2'd0);
        chk("rst_mid.ready", 32'(din_ready), 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_rel.ready", 32'(din_ready), 32'b0001);
        tick();
        chk_out("rst_rel", 1'b1, 8'hA0, 2'd0);

        // Backpressure: channel 2 only (ptr now 1).
        din_valid = 4'b0100;
        din       = {8'hD3, 8'h5A, 8'hB1, 8'hA0};
        #1;
        chk("bp.ready_pre", 32'(din_ready), 32'b0100);
        tick();
        chk_out("bp.load", 1'b1, 8'h5A, 2'd2);
        dout_ready = 1'b0;
        din        = {8'hD3, 8'h6C, 8'hB1, 8'hA0};
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp%0d.ready", i), 32'(din_ready), 32'h0);
            tick();
            chk_out($sformatf("bp%0d", i), 1'b1, 8'h5A, 2'd2);
        end
        dout_ready = 1'b1;
        #1;
        chk("bp.ready_rel", 32'(din_ready), 32'b0100);
        tick();
        chk_out("bp.refill", 1'b1, 8'h6C, 2'd2);

        // Pointer wrap: grant 3, then with 0 and 3 valid channel 0 wins.
        din_valid = 4'b1000;
        din       = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        #1;
        chk("wrap.ready3", 32'(din_ready), 32'b1000);
        tick();
        chk_out("wrap.g3", 1'b1, 8'hD3, 2'd3);
        din_valid = 4'b1001;
        #1;
        chk("wrap.ready0", 32'(din_ready), 32'b0001);
        tick();
        chk_out("wrap.g0", 1'b1, 8'hA0, 2'd0);
        chk("wrap.ready3b", 32'(din_ready), 32'b1000);
        tick();
        chk_out("wrap.g3b", 1'b1, 8'hD3, 2'd3);

        // Sparse: one beat on channel 1, then the register empties and holds data.
        din_valid = 4'b0010;
        din       = {8'hD3, 8'hC2, 8'h77, 8'hA0};
        tick();
        chk_out("sparse.beat", 1'b1, 8'h77, 2'd1);
        din_valid = 4'b0000;
        #1;
        chk("sparse.ready", 32'(din_ready), 32'h0);
        tick();
        chk_out("sparse.idle", 1'b0, 8'h77, 2'd1);

        // Loopback through the demux model: each channel, both data polarities.
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 4; k++) begin
                din          = {4{~lb_d[p]}};
                din[k*W +: W] = lb_d[p];
                din_valid    = 4'(1 << k);
                tick();
                lb = demux_model(dout_valid, sel, dout);
                chk($sformatf("lb%0d_%0d.lane_v", p, k), 32'(lb[4*W +: 4]), 32'(1 << k));
                chk($sformatf("lb%0d_%0d.lane_d", p, k), 32'(lb[k*W +: W]), 32'(lb_d[p]));
            end
        end
        din_valid = 4'b0000;
        tick();
        chk("lb.drain", 32'(dout_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr_4to1.md
# mux_rr_4to1

Sequential 4-to-1 round-robin multiplexer. It is the collecting end of the 1-to-4 demultiplexer path: four producer channels are merged onto one registered output stream. Each output beat carries a 2-bit `sel` tag using the same encoding the demux uses (00 = channel 0 … 11 = channel 3), so a downstream `demux_1to4` can route the beat back out. All transfers use a valid/ready handshake, with full throughput of one beat per clock.

## Interface
- `WIDTH`, default 8: data width of each channel and of the output.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `din_valid`  in  4  per-channel valid; bit i belongs to channel i.
- `din`  in  4*WIDTH  packed channel data; channel i is bits [i*WIDTH +: WIDTH].
- `din_ready`  out  4  per-channel accept; combinational, at most one bit set.
- `dout_valid`  out  1  output register holds a beat.
- `dout`  out  WIDTH  registered output data.
- `sel`  out  2  channel index of the beat in `dout`; registered.
- `dout_ready`  in  1  downstream accept.

## Operation
- Output register has two states:
  - EMPTY: `dout_valid` = 0.
  - FULL: `dout_valid` = 1.
- Load condition: `load = !dout_valid || dout_ready`.
- Arbitration:
  - Round-robin pointer `ptr` (2 bits) names the highest-priority channel.
  - Search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4).
  - The first channel in that order with `din_valid` set wins; the winner index is `gnt`.
- `din_ready[gnt]` = 1 only when `load` and some `din_valid` is set. All other `din_ready` bits are 0.
- On a transfer (`din_valid[gnt]` and `din_ready[gnt]`), at the next edge:
  - `dout` <= channel `gnt` data.
  - `sel` <= `gnt`.
  - `dout_valid` <= 1.
  - `ptr` <= `gnt + 1` (wraps 3 -> 0).
- If `load` and no `din_valid` is set:
  - `dout_valid` <= 0.
  - `dout` and `sel` hold their values.
  - `ptr` holds.
- If FULL and `dout_ready` = 0: `dout`, `sel`, `dout_valid` and `ptr` all hold, and every `din_ready` bit is 0.
- Simultaneous drain and refill (FULL, `dout_ready` = 1, some `din_valid` set): the new beat is loaded on the same edge, so `dout_valid` stays 1 with no bubble.
- Producers must keep `din` stable while valid and not yet accepted. Dropping `din_valid` before acceptance is legal and simply withdraws the request.

## Timing
- Reset values: `dout_valid` = 0, `dout` = 0, `sel` = 2'b00, `ptr` = 0.
- Reset is asynchronous and takes effect immediately, including mid-stall: a held beat is discarded and no `din_ready` is asserted while `rst` is high.
- Latency: a beat accepted at edge N appears on `dout`/`sel` with `dout_valid` high after edge N and stays until the edge where `dout_ready` = 1.
- `din_ready` depends combinationally on `dout_valid`, `dout_ready`, `din_valid` and `ptr`. There is no combinational path from `din` to `dout`.
- Throughput: one beat per cycle while `dout_ready` = 1.
- Fairness: with all four channels valid continuously, grants cycle 0,1,2,3,0,… Any requesting channel waits at most 3 grants.

## Structure
- Shared package `mux_pkg`:
  - `NCH` = 4.
  - `SEL_W` = 2.
  - typedef `sel_t` (logic [1:0]), shared with `demux_1to4` users.
- Sub-module `rr_arbiter_4`:
  - Inputs: `req[3:0]`, `ptr[1:0]`, `en`.
  - Outputs: one-hot `gnt_oh[3:0]`, encoded `gnt[1:0]`, `any`.
  - Purely combinational.
- The top level owns the `ptr` register and the output register.

## Test plan
- Reset: assert `rst` mid-beat with `dout_valid` = 1 -> same cycle `dout_valid` = 0, `dout` = 0, `sel` = 00. After release, with `din_valid` = 4'b1111, the first grant goes to channel 0.
- Fairness: all channels valid with `din` = {8'hD3, 8'hC2, 8'hB1, 8'hA0}, `dout_ready` = 1 -> `sel` sequence 0,1,2,3,0 and `dout` sequence A0, B1, C2, D3, A0, one per cycle with no bubbles.
- Backpressure: `dout_ready` = 0 for 5 cycles with channel 2 valid, `din` ch2 = 8'h5A -> `dout` = 5A and `sel` = 10 stay stable, `din_ready` = 0000 throughout. When `dout_ready` rises, the next beat loads on that edge.
- Pointer wrap: last grant was channel 3, now only channels 0 and 3 valid -> channel 0 is granted (`ptr` = 0), then channel 3.
- Sparse input: only channel 1 valid for one cycle, `din` = 8'h77 -> `dout` = 77 and `sel` = 01 for one cycle, then `dout_valid` = 0 while `dout`/`sel` hold.
- Loopback: drive `dout`/`sel` into `demux_1to4` -> the beat from channel k appears on demux output k, covering all four channels and both data polarities.
